// File: rtl/click_gen_pkg.sv
// rtl/click_gen_pkg.sv - shared request kinds, FSM states and window helper for click_gen
package click_gen_pkg;

    // Request kind codes, shared with the double_click detector side.
    localparam logic [1:0] KIND_SINGLE = 2'b00;
    localparam logic [1:0] KIND_DOUBLE = 2'b01;
    localparam logic [1:0] KIND_LONG   = 2'b10;
    localparam logic [1:0] KIND_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_GAP    = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_QUIET  = 3'd4
    } state_t;

    // Quiet time after the last press: two full detector windows, so the
    // detector has certainly closed its window before the next request.
    function automatic int quiet_len(input int wait_width);
        return 2 * (1 << wait_width);
    endfunction

endpackage

// File: rtl/click_timer.sv
// rtl/click_timer.sv - load/decrement phase timer with expire flag
//
// Ports:
//   clk       in  clock, rising edge
//   rst       in  synchronous reset, active-high
//   load      in  load load_val this cycle (wins over the decrement)
//   load_val  in  CNT_W phase length; a load of L gives expire on the L-th cycle
//   expire    out high while the count is 1, i.e. the last cycle of the phase
module click_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count;

    // Counts down to zero and parks there, so an idle timer never expires.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    assign expire = (count == ONE);

endmodule

// File: rtl/click_gen.sv
// rtl/click_gen.sv - button waveform generator for single, double and long clicks
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high; aborts any request in flight
//   req_valid  in   request present
//   req_kind   in   2 bits: 00 single, 01 double, 10 long, 11 reserved (rejected)
//   req_ready  out  high only when idle; a request transfers on req_valid & req_ready
//   button     out  registered button level
//   busy       out  high from accept until the quiet time expires
//   done       out  1-cycle pulse at end of quiet time or on reserved-kind reject
//   err        out  1-cycle pulse together with done for a reserved kind
module click_gen
    import click_gen_pkg::*;
#(
    parameter int WAIT_WIDTH = 4,
    parameter int PRESS_LEN  = 3,
    parameter int GAP_LEN    = 4,
    parameter int LONG_LEN   = 40,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_kind,
    output logic       req_ready,
    output logic       button,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [CNT_W-1:0] PRESS_V = CNT_W'(PRESS_LEN);
    localparam logic [CNT_W-1:0] GAP_V   = CNT_W'(GAP_LEN);
    localparam logic [CNT_W-1:0] LONG_V  = CNT_W'(LONG_LEN);
    localparam logic [CNT_W-1:0] QUIET_V = CNT_W'(quiet_len(WAIT_WIDTH));

    state_t           state, state_n;
    logic             dbl, dbl_n;
    logic             button_n, done_n, err_n;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             expire;

    click_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            dbl    <= 1'b0;
            button <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            dbl    <= dbl_n;
            button <= button_n;
            done   <= done_n;
            err    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        dbl_n    = dbl;
        done_n   = 1'b0;
        err_n    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    case (req_kind)
                        KIND_SINGLE: begin
                            state_n  = ST_PRESS1;
                            dbl_n    = 1'b0;
                            load     = 1'b1;
                            load_val = PRESS_V;
                        end
                        KIND_DOUBLE: begin
                            state_n  = ST_PRESS1;
                            dbl_n    = 1'b1;
                            load     = 1'b1;
                            load_val = PRESS_V;
                        end
                        KIND_LONG: begin
                            state_n  = ST_PRESS1;
                            dbl_n    = 1'b0;
                            load     = 1'b1;
                            load_val = LONG_V;
                        end
                        default: begin
                            // Reserved kind: consumed and rejected without a press.
                            done_n = 1'b1;
                            err_n  = 1'b1;
                        end
                    endcase
                end
            end
            ST_PRESS1: begin
                if (expire) begin
                    load = 1'b1;
                    if (dbl) begin
                        state_n  = ST_GAP;
                        load_val = GAP_V;
                    end else begin
                        state_n  = ST_QUIET;
                        load_val = QUIET_V;
                    end
                end
            end
            ST_GAP: begin
                if (expire) begin
                    state_n  = ST_PRESS2;
                    load     = 1'b1;
                    load_val = PRESS_V;
                end
            end
            ST_PRESS2: begin
                if (expire) begin
                    state_n  = ST_QUIET;
                    load     = 1'b1;
                    load_val = QUIET_V;
                end
            end
            ST_QUIET: begin
                if (expire) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Registered button follows the state being entered, so it is high
        // exactly while the FSM sits in a press phase.
        button_n = (state_n == ST_PRESS1) || (state_n == ST_PRESS2);
    end

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

endmodule
